// File: rtl/dm_pkg.sv
// Shared types and constants for the parametrised data memory.
package dm_pkg;

  // Two-state controller: normal access or hardware clear sweep.
  typedef enum logic {
    DM_IDLE  = 1'b0,
    DM_CLEAR = 1'b1
  } dm_state_t;

  // Zero word source; sliced down to the data width by users (DW <= 64).
  localparam logic [63:0] DM_ZERO = 64'd0;

endpackage

// File: rtl/dm_clear_seq.sv
// Clear sequencer: owns the IDLE/CLEAR state, the sweep pointer and the clear write port.
module dm_clear_seq #(
  parameter int unsigned AW             = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_req_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);
  import dm_pkg::*;

  // Pointer is one bit wider than the address so DEPTH == 2**AW ends without wrapping.
  localparam logic [AW:0] LastPtr = (AW+1)'(DEPTH - 1);

  dm_state_t     state_q, state_d;
  logic [AW:0]   clr_ptr_q, clr_ptr_d;

  // State and pointer registers; reset always restarts the sweep at word 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (CLEAR_ON_RESET != 0) begin
        state_q <= DM_CLEAR;
      end else begin
        state_q <= DM_IDLE;
      end
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next-state: a clear request starts a DEPTH-cycle sweep; requests during a sweep are ignored.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      DM_IDLE: begin
        if (clear_req_i) begin
          state_d   = DM_CLEAR;
          clr_ptr_d = '0;
        end
      end
      DM_CLEAR: begin
        if (clr_ptr_q == LastPtr) begin
          state_d   = DM_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
    endcase
  end

  // Clear port drives one word per cycle while sweeping.
  always_comb begin
    busy_o     = (state_q == DM_CLEAR);
    clr_we_o   = (state_q == DM_CLEAR);
    clr_addr_o = clr_ptr_q[AW-1:0];
  end

endmodule

// File: rtl/dm_param.sv
// Parametrised single-port data memory with optional registered read and hardware clear.
module dm_param #(
  parameter int unsigned DW             = 8,
  parameter int unsigned AW             = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned READ_LAT       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_write,
  input  logic          mem_read,
  input  logic          clear_req,
  input  logic [AW-1:0] rmo,
  input  logic [DW-1:0] rf_reg_out,
  input  logic [AW-1:0] rmi,
  output logic [DW-1:0] dm_out,
  output logic          rd_valid,
  output logic          busy
);
  import dm_pkg::*;

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  logic [DW-1:0] core [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr_in_range, rd_in_range, user_we;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd_word;

  dm_clear_seq #(
    .AW             (AW),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i       (clk),
    .rst_ni      (reset),
    .clear_req_i (clear_req),
    .busy_o      (busy),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  // User write is dropped while busy, when a clear starts this cycle, or when out of range.
  always_comb begin
    wr_in_range = ({1'b0, rmo} < DepthW);
    rd_in_range = ({1'b0, rmi} < DepthW);
    user_we     = mem_write & ~busy & ~clear_req & wr_in_range;
    mem_we      = clr_we | user_we;
    mem_addr    = clr_we ? clr_addr : rmo;
    mem_wdata   = clr_we ? DM_ZERO[DW-1:0] : rf_reg_out;
    rd_word     = rd_in_range ? core[rmi] : DM_ZERO[DW-1:0];
  end

  // Storage write port, shared by the clear sweep and user writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      core[mem_addr] <= mem_wdata;
    end
  end

  if (READ_LAT == 0) begin : g_comb_read
    // Legacy timing: data follows rmi within the cycle.
    assign dm_out   = busy ? DM_ZERO[DW-1:0] : rd_word;
    assign rd_valid = mem_read & ~busy;
  end else begin : g_reg_read
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;

    // Capture on an accepted read; same-edge write to the read address is forwarded.
    always_comb begin
      valid_d = mem_read & ~busy;
      dout_d  = dout_q;
      if (valid_d) begin
        dout_d = (user_we && (rmo == rmi)) ? rf_reg_out : rd_word;
      end
    end

    // Read data and valid registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    // A read captured on the edge that starts a clear must not surface while busy.
    assign dm_out   = busy ? DM_ZERO[DW-1:0] : dout_q;
    assign rd_valid = valid_q & ~busy;
  end

endmodule

// File: tb/tb_dm_param.sv
// Bench for dm_param: combinational, registered and reduced-depth instances share stimulus.
module tb_dm_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mem_write = 1'b0;
  logic       mem_read = 1'b0;
  logic       clear_req = 1'b0;
  logic [7:0] rmo = 8'd0;
  logic [7:0] rf_reg_out = 8'd0;
  logic [7:0] rmi = 8'd0;

  logic [7:0] dm_out_c, dm_out_r, dm_out_s;
  logic       rdv_c, rdv_r, rdv_s;
  logic       busy_c, busy_r, busy_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] m256 [256];
  logic [7:0] m200 [200];
  logic [7:0] q_c[$];
  logic [7:0] q_r[$];
  logic [7:0] q_s[$];
  logic [7:0] e_c, e_r, e_s;

  always #5 clk = ~clk;

  dm_param #(.DW(8), .AW(8), .DEPTH(256), .READ_LAT(0), .CLEAR_ON_RESET(1)) u_c (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .clear_req(clear_req), .rmo(rmo), .rf_reg_out(rf_reg_out), .rmi(rmi),
    .dm_out(dm_out_c), .rd_valid(rdv_c), .busy(busy_c)
  );

  dm_param #(.DW(8), .AW(8), .DEPTH(256), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_r (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .clear_req(clear_req), .rmo(rmo), .rf_reg_out(rf_reg_out), .rmi(rmi),
    .dm_out(dm_out_r), .rd_valid(rdv_r), .busy(busy_r)
  );

  dm_param #(.DW(8), .AW(8), .DEPTH(200), .READ_LAT(0), .CLEAR_ON_RESET(1)) u_s (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .clear_req(clear_req), .rmo(rmo), .rf_reg_out(rf_reg_out), .rmi(rmi),
    .dm_out(dm_out_s), .rd_valid(rdv_s), .busy(busy_s)
  );

  // Scoreboard: every rd_valid pops the oldest expected word for that instance.
  always @(negedge clk) begin
    if (rdv_c) begin
      checks++;
      if (q_c.size() == 0) begin
        errors++;
        $display("FAIL sb_c: rd_valid=1 dm_out=%h, required no read pending", dm_out_c);
      end else begin
        e_c = q_c.pop_front();
        if (dm_out_c !== e_c) begin
          errors++;
          $display("FAIL sb_c: rmi=%0d dm_out=%h required %h", rmi, dm_out_c, e_c);
        end
      end
    end
    if (rdv_r) begin
      checks++;
      if (q_r.size() == 0) begin
        errors++;
        $display("FAIL sb_r: rd_valid=1 dm_out=%h, required no read pending", dm_out_r);
      end else begin
        e_r = q_r.pop_front();
        if (dm_out_r !== e_r) begin
          errors++;
          $display("FAIL sb_r: dm_out=%h required %h", dm_out_r, e_r);
        end
      end
    end
    if (rdv_s) begin
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL sb_s: rd_valid=1 dm_out=%h, required no read pending", dm_out_s);
      end else begin
        e_s = q_s.pop_front();
        if (dm_out_s !== e_s) begin
          errors++;
          $display("FAIL sb_s: rmi=%0d dm_out=%h required %h", rmi, dm_out_s, e_s);
        end
      end
    end
  end

  // Drive one cycle of inputs; push read expectations and update the models.
  task automatic drive_cycle(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                             input logic r, input logic [7:0] ra, input logic clr,
                             input logic exp_busy);
    @(posedge clk);
    #1;
    mem_write  = w;
    rmo        = wa;
    rf_reg_out = wd;
    mem_read   = r;
    rmi        = ra;
    clear_req  = clr;
    if (!exp_busy) begin
      if (r) begin
        q_c.push_back(m256[ra]);
        q_r.push_back((w && !clr && (wa == ra)) ? wd : m256[ra]);
        q_s.push_back((ra < 8'd200) ? m200[ra] : 8'h00);
      end
      if (w && !clr) begin
        m256[wa] = wd;
        if (wa < 8'd200) m200[wa] = wd;
      end
      if (clr) begin
        for (int i = 0; i < 256; i++) m256[i] = 8'h00;
        for (int i = 0; i < 200; i++) m200[i] = 8'h00;
      end
    end
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  // Count busy cycles from now on; bounded so a stuck busy cannot hang the run.
  task automatic count_busy(output int cnt_c, output int cnt_r, output int cnt_s);
    cnt_c = 0;
    cnt_r = 0;
    cnt_s = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy_c) cnt_c++;
      if (busy_r) cnt_r++;
      if (busy_s) cnt_s++;
      if (!busy_c && !busy_r && !busy_s) break;
    end
  endtask

  task automatic test_reset();
    int cc, cr, cs;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy_c, busy_r, busy_s} !== 3'b111) begin
      errors++;
      $display("FAIL reset_busy: busy c/r/s=%b required 111", {busy_c, busy_r, busy_s});
    end
    checks++;
    if (dm_out_r !== 8'h00 || rdv_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdout: dm_out=%h rd_valid=%b required 00/0", dm_out_r, rdv_r);
    end
    reset = 1'b1;
    count_busy(cc, cr, cs);
    checks++;
    if (cc != 256 || cr != 256 || cs != 200) begin
      errors++;
      $display("FAIL reset_clear_len: c/r/s=%0d/%0d/%0d required 256/256/200", cc, cr, cs);
    end
  endtask

  task automatic test_clear_zero();
    for (int a = 0; a < 256; a++) drive_cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'(a), 1'b0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_comb_read();
    drive_cycle(1'b1, 8'd10, 8'd155, 1'b0, 8'd0, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd10, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (dm_out_c !== 8'd155 || rdv_c !== 1'b1) begin
      errors++;
      $display("FAIL comb_read: dm_out=%0d rd_valid=%b required 155/1", dm_out_c, rdv_c);
    end
    idle_cycle();
  endtask

  task automatic test_reg_bypass();
    drive_cycle(1'b1, 8'd3, 8'hA5, 1'b1, 8'd3, 1'b0, 1'b0);
    idle_cycle();
    @(negedge clk);
    checks++;
    if (dm_out_r !== 8'hA5 || rdv_r !== 1'b1) begin
      errors++;
      $display("FAIL reg_bypass: dm_out=%h rd_valid=%b required a5/1", dm_out_r, rdv_r);
    end
    idle_cycle();
    @(negedge clk);
    checks++;
    if (rdv_r !== 1'b0 || dm_out_r !== 8'hA5) begin
      errors++;
      $display("FAIL reg_hold: dm_out=%h rd_valid=%b required a5/0", dm_out_r, rdv_r);
    end
  endtask

  task automatic test_clear_blocks();
    int cnt;
    drive_cycle(1'b1, 8'd5, 8'h5A, 1'b0, 8'd0, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    cnt = 0;
    // Clear cycle 1: a repeated request must be ignored.
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1);
    @(negedge clk);
    if (busy_c) cnt++;
    // Clear cycle 2: write and read are both blocked.
    drive_cycle(1'b1, 8'd5, 8'h77, 1'b1, 8'd5, 1'b0, 1'b1);
    @(negedge clk);
    if (busy_c) cnt++;
    checks++;
    if (busy_c !== 1'b1 || dm_out_c !== 8'h00 || rdv_c !== 1'b0 || dm_out_r !== 8'h00) begin
      errors++;
      $display("FAIL busy_block: busy=%b dm_out_c=%h rd_valid=%b dm_out_r=%h required 1/00/0/00",
               busy_c, dm_out_c, rdv_c, dm_out_r);
    end
    for (int i = 0; i < 300; i++) begin
      idle_cycle();
      @(negedge clk);
      if (busy_c) cnt++;
      else break;
    end
    checks++;
    if (cnt != 256) begin
      errors++;
      $display("FAIL clear_len: busy cycles=%0d required 256", cnt);
    end
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (dm_out_c !== 8'h00 || rdv_c !== 1'b1) begin
      errors++;
      $display("FAIL dropped_write: dm_out=%h rd_valid=%b required 00/1", dm_out_c, rdv_c);
    end
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd10, 1'b0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_reset_mid_clear();
    int cc, cr, cs;
    drive_cycle(1'b1, 8'd1, 8'h3C, 1'b1, 8'd1, 1'b0, 1'b0);
    idle_cycle();
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) idle_cycle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (dm_out_c !== 8'h00 || dm_out_r !== 8'h00 || dm_out_s !== 8'h00) begin
      errors++;
      $display("FAIL midclear_out: dm_out c/r/s=%h/%h/%h required 00", dm_out_c, dm_out_r,
               dm_out_s);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    count_busy(cc, cr, cs);
    checks++;
    if (cc != 256 || cr != 256 || cs != 200) begin
      errors++;
      $display("FAIL midclear_len: c/r/s=%0d/%0d/%0d required 256/256/200", cc, cr, cs);
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 8'(i * 13), 8'(i * 7 + 1), 1'b0, 8'd0, 1'b0, 1'b0);
    end
    drive_cycle(1'b1, 8'd250, 8'h33, 1'b0, 8'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'd200, 8'h44, 1'b0, 8'd0, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd250, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (dm_out_s !== 8'h00 || rdv_s !== 1'b1 || dm_out_c !== 8'h33) begin
      errors++;
      $display("FAIL oor_read: dm_out_s=%h rd_valid_s=%b dm_out_c=%h required 00/1/33",
               dm_out_s, rdv_s, dm_out_c);
    end
    // Back-to-back sweep of every address on all three instances.
    for (int a = 0; a < 256; a++) drive_cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'(a), 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m256[i] = 8'h00;
    for (int i = 0; i < 200; i++) m200[i] = 8'h00;
    test_reset();
    test_clear_zero();
    test_comb_read();
    test_reg_bypass();
    test_clear_blocks();
    test_reset_mid_clear();
    test_out_of_range();
    checks++;
    if (q_c.size() != 0 || q_r.size() != 0 || q_s.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending c/r/s=%0d/%0d/%0d required 0/0/0", q_c.size(),
               q_r.size(), q_s.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
